mem_bus_arbiter: RTL and testbench

- Shares the single data-memory port between the pipelined CPU's MEM stage (MemBus) and a secondary requester (DMA / program loader).
- CPU has absolute, zero-latency priority. The CPU has no stall input, so it must never wait.
- The secondary port uses a req/ack handshake. It is served only in cycles where the CPU issues no memory access.
- Provides starvation status and a completed-transfer counter for debug.

---
 rtl/mem_bus_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Data-memory port arbiter: the CPU MEM stage passes straight through with
// absolute priority, and a req/ack secondary port is served in CPU-idle cycles.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned WAIT_W   = 8,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  // CPU MEM stage
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  // memory port
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  // secondary requester
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic              dma_err,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_starved,
  output logic [CNT_W-1:0]  xfer_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [WAIT_W-1:0] WAIT_SAT    = {WAIT_W{1'b1}};
  localparam logic [WAIT_W-1:0] WAIT_THRESH = WAIT_W'(MAX_WAIT);

  state_t              state;
  state_t              state_nxt;

  logic                cpu_active;
  logic                dma_aligned;
  logic                capture;
  logic                reject;
  logic                grant;

  logic [ADDR_W-1:0]   hold_addr;
  logic                hold_we;
  logic [DATA_W-1:0]   hold_wdata;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                err_q;

  assign cpu_active  = cpu_read | cpu_write;
  assign dma_aligned = (dma_addr[1:0] == 2'b00);
  assign cpu_rdata   = mem_rdata;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a CPU access always defers the pending grant
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (dma_req) begin
          state_nxt = dma_aligned ? PEND : RESP;
        end
      end
      PEND: begin
        if (!cpu_active) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output decode and memory-port mux
  always_comb begin
    capture     = 1'b0;
    reject      = 1'b0;
    grant       = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    dma_ack     = 1'b0;
    dma_err     = 1'b0;
    dma_starved = 1'b0;

    case (state)
      IDLE: begin
        capture = dma_req & dma_aligned;
        reject  = dma_req & ~dma_aligned;
      end
      PEND: begin
        grant       = ~cpu_active;
        dma_starved = (wait_cnt >= WAIT_THRESH);
      end
      RESP: begin
        dma_ack = 1'b1;
        dma_err = err_q;
      end
      default: begin
      end
    endcase

    if (cpu_active) begin
      mem_read  = cpu_read;
      mem_write = cpu_write;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (grant) begin
      mem_read  = ~hold_we;
      mem_write = hold_we;
      mem_addr  = hold_addr;
      mem_wdata = hold_wdata;
    end
  end

  // Request hold registers, wait counter and error flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_addr  <= '0;
      hold_we    <= 1'b0;
      hold_wdata <= '0;
      wait_cnt   <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= reject;
      if (capture) begin
        hold_addr  <= dma_addr;
        hold_we    <= dma_we;
        hold_wdata <= dma_wdata;
        wait_cnt   <= '0;
      end else if (state == PEND && cpu_active && wait_cnt != WAIT_SAT) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
    end
  end

  // Read-data capture and completed-transfer counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dma_rdata <= '0;
      xfer_cnt  <= '0;
    end else if (grant) begin
      if (!hold_we) begin
        dma_rdata <= mem_rdata;
      end
      xfer_cnt <= xfer_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized scoreboard bench for mem_bus_arbiter with a word-array memory
// and a transaction-level reference memory.
module tb_mem_bus_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned MAXW = 16;
  localparam int unsigned WW   = 8;
  localparam int unsigned CW   = 4;

  logic          clk;
  logic          reset;
  logic          cpu_read, cpu_write;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          dma_req, dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_ack, dma_err, dma_starved;
  logic [DW-1:0] dma_rdata;
  logic [CW-1:0] xfer_cnt;

  mem_bus_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAXW), .WAIT_W(WW), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_ack(dma_ack), .dma_err(dma_err),
    .dma_rdata(dma_rdata), .dma_starved(dma_starved), .xfer_cnt(xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment memory: asynchronous read, write on rising edge
  logic [31:0] mem     [0:2047];
  logic [31:0] ref_mem [0:2047];
  assign mem_rdata = mem[mem_addr[12:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[12:2]] = mem_wdata;

  function automatic logic [31:0] init_val(input int i);
    return 32'hC0DE_0000 ^ 32'(i * 40503);
  endfunction

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endfunction

  typedef struct {
    int          cyc;
    logic        err;
    logic        we;
    logic [31:0] rdata;
    logic [CW-1:0] cnt;
  } exp_t;
  exp_t sbq[$];

  // Per-cycle expectations published by the driver
  int          exp_bus;   // 0 idle, 1 cpu, 2 secondary grant
  logic        exp_we;
  logic [31:0] exp_addr, exp_wdata;
  logic        exp_starved;
  logic [CW-1:0] cnt_model;

  // Monitor: bus ownership, starvation flag and scoreboard pops on ack
  always @(negedge clk) begin
    if (reset) begin
      chk("cpu_rdata_pass", 96'(cpu_rdata), 96'(mem_rdata));
      case (exp_bus)
        1: begin
          chk("bus_cpu", 96'({mem_read, mem_write, mem_addr, mem_wdata}),
              96'({cpu_read, cpu_write, cpu_addr, cpu_wdata}));
          if (cpu_read) chk("cpu_read_data", 96'(cpu_rdata), 96'(ref_mem[cpu_addr[12:2]]));
        end
        2: begin
          chk("bus_dma", 96'({mem_read, mem_write, mem_addr}), 96'({~exp_we, exp_we, exp_addr}));
          if (exp_we) chk("bus_dma_wdata", 96'(mem_wdata), 96'(exp_wdata));
        end
        default: chk("bus_idle", 96'({mem_read, mem_write, mem_addr, mem_wdata}), 96'(0));
      endcase
      chk("dma_starved", 96'(dma_starved), 96'(exp_starved));
      if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
        chk("dma_ack", 96'(dma_ack), 96'(1));
        chk("dma_err", 96'(dma_err), 96'(sbq[0].err));
        chk("xfer_cnt", 96'(xfer_cnt), 96'(sbq[0].cnt));
        if (!sbq[0].we && !sbq[0].err) chk("dma_rdata", 96'(dma_rdata), 96'(sbq[0].rdata));
        void'(sbq.pop_front());
      end else begin
        chk("no_ack", 96'({dma_ack, dma_err}), 96'(0));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 idle, 1 busy, 2 random
  task automatic cpu_set(input int mode);
    logic busy;
    busy = (mode == 1) || (mode == 2 && $urandom_range(0, 1) == 1);
    if (busy) begin
      cpu_read  = 1'($urandom_range(0, 1));
      cpu_write = ~cpu_read;
      cpu_addr  = 32'h1000 + 32'($urandom_range(0, 1023)) * 4;
      cpu_wdata = $urandom;
      if (cpu_write) ref_mem[cpu_addr[12:2]] = cpu_wdata;
      exp_bus = 1;
    end else begin
      cpu_read  = 1'b0;
      cpu_write = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      exp_bus   = 0;
    end
  endtask

  // One secondary transaction with k CPU-occupied PEND cycles
  task automatic do_dma(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input int k, input int edge_mode);
    exp_t e;
    logic mis;
    mis = (a[1:0] != 2'b00);
    dma_req = 1'b1; dma_addr = a; dma_we = w; dma_wdata = d;
    cpu_set(edge_mode);
    exp_starved = 1'b0;
    e.we = w; e.err = mis; e.rdata = ref_mem[a[12:2]];
    if (!mis) begin
      cnt_model = cnt_model + CW'(1);
      if (w) ref_mem[a[12:2]] = d;
    end
    e.cnt = cnt_model;
    e.cyc = cyc + (mis ? 1 : k + 2);
    sbq.push_back(e);
    step();
    if (!mis) begin
      for (int j = 0; j < k; j++) begin
        dma_addr = $urandom; dma_wdata = $urandom; dma_we = 1'($urandom_range(0, 1));
        cpu_set(1);
        exp_starved = (j >= int'(MAXW));
        step();
      end
      cpu_set(0);
      exp_bus = 2; exp_we = w; exp_addr = a; exp_wdata = d;
      exp_starved = (k >= int'(MAXW));
      step();
    end
    cpu_set(edge_mode);
    exp_starved = 1'b0;
    step();
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    cpu_set(0);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin
      mem[i]     = init_val(i);
      ref_mem[i] = init_val(i);
    end
    reset = 1'b0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    cnt_model = '0; exp_starved = 1'b0;
    cpu_set(0);
    #2;
    chk("reset_outputs", 96'({dma_ack, dma_err, dma_starved, dma_rdata, xfer_cnt}), 96'(0));
    step();
    reset = 1'b1;
    step();

    // CPU-only accesses; the second seeds word 0x20 for the secondary read
    cpu_read = 1'b0; cpu_write = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
    ref_mem[4] = 32'hDEADBEEF; exp_bus = 1;
    #1;
    chk("cpu_write_pass", 96'({mem_write, mem_addr, mem_wdata}), 96'({1'b1, 32'h10, 32'hDEADBEEF}));
    step();
    cpu_addr = 32'h20; cpu_wdata = 32'h12345678; ref_mem[8] = 32'h12345678;
    step();
    cpu_set(0);
    step();

    do_dma(32'h20, 1'b0, 32'h0, 0, 0);
    do_dma(32'h40, 1'b1, 32'hA5A5A5A5, 19, 1);
    do_dma(32'h40, 1'b0, 32'h0, 0, 0);
    do_dma(32'h22, 1'b1, 32'h55AA55AA, 0, 0);
    step();

    // Reset while a write is pending behind a busy CPU
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h30; dma_wdata = 32'hBAD0BAD0;
    cpu_set(1);
    step();
    for (int j = 0; j < 5; j++) begin
      cpu_set(1);
      step();
    end
    reset = 1'b0;
    #1;
    chk("midreset_outputs", 96'({dma_ack, dma_err, dma_starved, dma_rdata, xfer_cnt}), 96'(0));
    step();
    step();
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    cnt_model = '0;
    cpu_set(0);
    reset = 1'b1;
    for (int j = 0; j < 5; j++) step();
    do_dma(32'h30, 1'b0, 32'h0, 0, 0);

    for (int t = 0; t < 3; t++) do_dma(32'h4 * 32'(t), 1'b1, $urandom, 0, 0);
    do_dma(32'h8, 1'b1, 32'h0BADF00D, 270, 2);

    for (int t = 0; t < 60; t++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 15)) * 4;
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      do_dma(a, 1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 24)), 2);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        cpu_set(2);
        step();
      end
      cpu_set(0);
    end
    for (int j = 0; j < 4; j++) step();
    chk("scoreboard_drained", 96'(sbq.size()), 96'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
